// File: rtl/controlador_teclado_pkg.sv
// Shared definitions for the keypad controller: per-channel FSM encoding and
// default parameter values.
package controlador_teclado_pkg;

  localparam int unsigned DEF_N_BOTOES  = 4;
  localparam int unsigned DEF_DEB_W     = 8;
  localparam int unsigned DEF_LONG_W    = 16;
  localparam bit          DEF_REPEAT_EN = 1'b1;

  typedef logic [1:0] canal_estado_t;

  localparam canal_estado_t ST_SOLTO      = 2'd0;
  localparam canal_estado_t ST_CONF_PRESS = 2'd1;
  localparam canal_estado_t ST_PRESS      = 2'd2;
  localparam canal_estado_t ST_CONF_SOLTO = 2'd3;

endpackage

// File: rtl/controlador_canal.sv
// One button channel: 2-flop synchroniser, debounce FSM, and registered
// press / long-press / release pulses.
module controlador_canal
  import controlador_teclado_pkg::*;
#(
  parameter int unsigned DEB_W     = DEF_DEB_W,
  parameter int unsigned LONG_W    = DEF_LONG_W,
  parameter bit          REPEAT_EN = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b_i,
  output logic press_o,
  output logic long_o,
  output logic release_o,
  output logic estado_o
);

  localparam logic [DEB_W-1:0]  MAX_DEB  = '1;
  localparam logic [LONG_W-1:0] MAX_HOLD = '1;

  logic [1:0]        sync_q;
  canal_estado_t     state_q, state_d;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [LONG_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              press_q, press_d;
  logic              long_q, long_d;
  logic              release_q, release_d;
  logic              smp;

  assign smp = sync_q[1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    done_d    = done_q;
    press_d   = 1'b0;
    long_d    = 1'b0;
    release_d = 1'b0;
    case (state_q)
      ST_SOLTO: begin
        if (!smp) begin
          state_d = ST_CONF_PRESS;
          deb_d   = '0;
        end
      end
      ST_CONF_PRESS: begin
        if (smp) begin
          state_d = ST_SOLTO;
          deb_d   = '0;
        end else if (deb_q == MAX_DEB) begin
          state_d = ST_PRESS;
          hold_d  = '0;
          done_d  = 1'b0;
          press_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_PRESS: begin
        if (smp) begin
          // The exit cycle still counts as PRESS time, but a pending period
          // end waits for the return to PRESS rather than pulsing in CONF_SOLTO.
          state_d = ST_CONF_SOLTO;
          deb_d   = '0;
          if (hold_q != MAX_HOLD) hold_d = hold_q + 1'b1;
        end else if (hold_q == MAX_HOLD) begin
          long_d = !done_q;
          if (REPEAT_EN) hold_d = '0;
          else           done_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_CONF_SOLTO: begin
        if (!smp) begin
          state_d = ST_PRESS;
        end else if (deb_q == MAX_DEB) begin
          state_d   = ST_SOLTO;
          release_d = 1'b1;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = ST_SOLTO;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state_q   <= ST_SOLTO;
      deb_q     <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      press_q   <= 1'b0;
      long_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], b_i};
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      press_q   <= press_d;
      long_q    <= long_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign long_o    = long_q;
  assign release_o = release_q;
  assign estado_o  = (state_q == ST_PRESS) || (state_q == ST_CONF_SOLTO);

endmodule

// File: rtl/controlador_teclado.sv
// Keypad controller top: N_BOTOES independent debounced channels with
// press, long-press and release pulses.
module controlador_teclado
  import controlador_teclado_pkg::*;
#(
  parameter int unsigned N_BOTOES  = DEF_N_BOTOES,
  parameter int unsigned DEB_W     = DEF_DEB_W,
  parameter int unsigned LONG_W    = DEF_LONG_W,
  parameter bit          REPEAT_EN = DEF_REPEAT_EN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_BOTOES-1:0] b_in,
  output logic [N_BOTOES-1:0] press_out,
  output logic [N_BOTOES-1:0] long_out,
  output logic [N_BOTOES-1:0] release_out,
  output logic [N_BOTOES-1:0] estado
);

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
    controlador_canal #(
      .DEB_W    (DEB_W),
      .LONG_W   (LONG_W),
      .REPEAT_EN(REPEAT_EN)
    ) u_canal (
      .clk      (clk),
      .rst_n    (rst_n),
      .b_i      (b_in[g]),
      .press_o  (press_out[g]),
      .long_o   (long_out[g]),
      .release_o(release_out[g]),
      .estado_o (estado[g])
    );
  end

endmodule

// File: doc/controlador_teclado.md
CONTROLADOR_TECLADO -- requirements
Module: controlador_teclado

Interface
REQ-001 Parameter N_BOTOES, default 4, number of independent button channels (1..32).
REQ-002 Parameter DEB_W, default 8, debounce counter width; stability threshold MAX_DEB = 2^DEB_W-1.
REQ-003 Parameter LONG_W, default 16, hold counter width; long-press period 2^LONG_W cycles.
REQ-004 Parameter REPEAT_EN, default 1, 1 = long_out repeats while held, 0 = single long_out per press.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 b_in  input  N_BOTOES  raw asynchronous button levels, active-low (0 = pressed).
REQ-008 press_out  output  N_BOTOES  one-cycle pulse per debounced press.
REQ-009 long_out  output  N_BOTOES  one-cycle pulse per long-press period held.
REQ-010 release_out  output  N_BOTOES  one-cycle pulse per debounced release.
REQ-011 estado  output  N_BOTOES  debounced level, 1 = pressed (high in PRESS and CONF_SOLTO).

Function
REQ-012 Each channel SHALL pass b_in through a 2-flop synchroniser; "sample" below means the synchronised value.
REQ-013 Each channel SHALL run an independent FSM: SOLTO, CONF_PRESS, PRESS, CONF_SOLTO.
REQ-014 SOLTO: sample 0 -> CONF_PRESS, deb_cnt cleared to 0; otherwise stay.
REQ-015 CONF_PRESS: sample 0 and deb_cnt < MAX_DEB -> deb_cnt+1; sample 0 and deb_cnt == MAX_DEB -> PRESS; sample 1 -> SOLTO, deb_cnt cleared (bounce restarts count).
REQ-016 press_out SHALL be high exactly in the first cycle the channel is in PRESS (cycle P), i.e. after 2^DEB_W+1 consecutive low samples.
REQ-017 PRESS: sample 1 -> CONF_SOLTO, deb_cnt cleared; otherwise hold_cnt increments.
REQ-018 hold_cnt SHALL clear to 0 on entry to PRESS from CONF_PRESS and SHALL freeze (not clear) in CONF_SOLTO.
REQ-019 long_out SHALL first pulse at cycle P+2^LONG_W, counting only cycles spent in PRESS.
REQ-020 REPEAT_EN=1: hold_cnt wraps, long_out repeats every 2^LONG_W PRESS cycles; REPEAT_EN=0: hold_cnt saturates, no further long_out until the next press.
REQ-021 CONF_SOLTO: sample 1 and deb_cnt == MAX_DEB -> SOLTO with release_out high in the first SOLTO cycle; sample 1 otherwise deb_cnt+1; sample 0 -> PRESS without press_out, hold_cnt resumes.
REQ-022 press_out, long_out, release_out SHALL be registered and never high for two consecutive cycles on one channel, except that long_out SHALL not pulse in CONF_SOLTO.
REQ-023 Channels SHALL be fully independent; any combination of channels may pulse in the same cycle.
REQ-024 deb_cnt SHALL never wrap; it stops at MAX_DEB.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force every channel to SOLTO, clear deb_cnt, hold_cnt and synchroniser flops to their released value (1), and drive all outputs 0 in the next cycle.
REQ-026 A button held through reset SHALL, after rst_n rises, go through full debounce and produce press_out.
REQ-027 Reset mid-PRESS SHALL not produce release_out.

Structure
REQ-028 Package controlador_teclado_pkg SHALL hold the FSM state typedef/encoding and default parameter constants.
REQ-029 Per-channel logic SHALL live in sub-module controlador_canal, instantiated N_BOTOES times by generate.

Verification (DEB_W=2, LONG_W=4, N_BOTOES=4)
REQ-030 Clean press: b_in[0]=0 held 40 cycles -> press_out[0] once after 5 low samples (+2 sync), long_out[0] at P+16 and P+32, release_out[0] 5 high samples after release.
REQ-031 Bounce: b_in[1] low 3 cycles, high 1, low 10 -> no pulse for the first burst; press_out[1] once, 5 samples after the last rising bounce.
REQ-032 REPEAT_EN=0: b_in[2] held 50 cycles -> exactly one long_out[2], at P+16.
REQ-033 Release glitch: in PRESS, b_in[3] high 2 cycles then low -> no release_out, no second press_out, long_out timing shifted by 2 cycles.
REQ-034 Simultaneous: all b_in=0 same cycle -> all press_out high same cycle.
REQ-035 Reset: rst_n=0 while channel 0 in PRESS with b_in held low -> outputs 0, no release_out; after rst_n=1, press_out[0] again after full debounce.
